// File: rtl/rd_return_pkg.sv
// ---------------------------------------------------------------------------
// rd_return_pkg
//   Shared types and default constants for the read-return sequencer
//   (rd_return_sched) and its outstanding-read queue (rd_tid_fifo).
//
//   Contents:
//     rd_state_e  - sequencer states
//     rd_entry_t  - queue entry {tid, raw} at the default TID width
//     *_DEF       - default parameter values
//     idx_width() - width of an index over n items, never less than 1
// ---------------------------------------------------------------------------
package rd_return_pkg;

  localparam int unsigned RD_TID_SIZE_DEF       = 2;
  localparam int unsigned RD_QDEPTH_DEF         = 4;
  localparam int unsigned RD_BURST_BEATS_DEF    = 4;
  localparam int unsigned RD_TIMEOUT_CYCLES_DEF = 64;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAW_XFER  = 3'd1,
    DRAM_WAIT = 3'd2,
    DRAM_XFER = 3'd3,
    TID_POP   = 3'd4
  } rd_state_e;

  typedef struct packed {
    logic [RD_TID_SIZE_DEF-1:0] tid;
    logic                       raw;
  } rd_entry_t;

  // Index width for n items; a single item still gets a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rd_tid_fifo.sv
// ---------------------------------------------------------------------------
// rd_tid_fifo
//   Synchronous FIFO holding outstanding read entries in issue order.
//   Push and pop in the same cycle are both honoured. A push into a full
//   FIFO or a pop from an empty FIFO is ignored. The head entry is read
//   combinationally from the storage array so the sequencer can look at it
//   in the same cycle it is first valid.
//
//   Parameters:
//     DEPTH   - number of entries
//     entry_t - entry type (defaults to rd_entry_t)
//
//   Ports:
//     clk          in   clock, rising edge
//     rst          in   asynchronous active-high reset (empties the FIFO)
//     push_i       in   write push_data_i at the tail
//     push_data_i  in   entry to write
//     pop_i        in   discard the head entry
//     head_o       out  current head entry (valid when !empty_o)
//     full_o       out  no free entries
//     empty_o      out  no entries held
// ---------------------------------------------------------------------------
module rd_tid_fifo
  import rd_return_pkg::*;
#(
  parameter int unsigned DEPTH   = RD_QDEPTH_DEF,
  parameter type         entry_t = rd_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push_i,
  input  entry_t push_data_i,
  input  logic   pop_i,
  output entry_t head_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int unsigned AW = idx_width(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Explicit wrap keeps the pointers in range for any DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/rd_return_sched.sv
// ---------------------------------------------------------------------------
// rd_return_sched
//   Read-return sequencer for the DDR controller data buffer. Keeps an
//   in-order queue of outstanding reads ({tid, raw}) and, for the head entry,
//   either gates DRAM beat pairs into the buffer (strobe) or pulls forwarded
//   beat pairs from the write buffer (fwd_req / raw_strobe), then retires the
//   TID with a one-cycle tid_strobe / tid_pop. Owns the DRAM/forward data mux
//   select.
//
//   Optional build macro: RD_RETURN_TIMEOUT_EN
//     Adds a DRAM_WAIT watchdog: after TIMEOUT_CYCLES cycles without
//     dram_valid the head is dropped (no tid_strobe) and err_timeout pulses.
//     Without the macro DRAM_WAIT waits indefinitely and err_timeout is 0.
//
//   Ports:
//     clk          in   clock, rising edge
//     rst          in   asynchronous active-high reset
//     cmd_valid    in   read issued to DRAM or RAW hit
//     cmd_ready    out  queue not full (combinational)
//     cmd_tid      in   TID of the read
//     cmd_raw      in   1 = data comes from the write-buffer forward path
//     dram_valid   in   DRAM beat pair present this cycle
//     fwd_req      out  request a forwarded beat pair
//     fwd_idx      out  index of the requested beat pair
//     mux_sel      out  0 = DRAM data, 1 = forward data
//     strobe       out  data_buffer strobe (dram_valid gated, combinational)
//     raw_strobe   out  data_buffer raw_strobe
//     tid_strobe   out  data_buffer tid_strobe
//     tid_pop      out  data_buffer tid_pop
//     busy         out  sequencer active or queue non-empty
//     err_unexp    out  pulse, the cycle after an unexpected/missing DRAM beat
//     err_timeout  out  pulse, the cycle after a watchdog expiry
// ---------------------------------------------------------------------------
module rd_return_sched
  import rd_return_pkg::*;
#(
  parameter int unsigned TID_SIZE       = RD_TID_SIZE_DEF,
  parameter int unsigned QDEPTH         = RD_QDEPTH_DEF,
  parameter int unsigned BURST_BEATS    = RD_BURST_BEATS_DEF,
  parameter int unsigned TIMEOUT_CYCLES = RD_TIMEOUT_CYCLES_DEF
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  cmd_valid,
  output logic                                  cmd_ready,
  input  logic [TID_SIZE-1:0]                   cmd_tid,
  input  logic                                  cmd_raw,
  input  logic                                  dram_valid,
  output logic                                  fwd_req,
  output logic [idx_width(BURST_BEATS/2)-1:0]   fwd_idx,
  output logic                                  mux_sel,
  output logic                                  strobe,
  output logic                                  raw_strobe,
  output logic                                  tid_strobe,
  output logic [TID_SIZE-1:0]                   tid_pop,
  output logic                                  busy,
  output logic                                  err_unexp,
  output logic                                  err_timeout
);

  // DDR delivers two 64-bit beats per clock.
  localparam int unsigned BURST_CYCLES = BURST_BEATS / 2;
  localparam int unsigned IDX_W        = idx_width(BURST_CYCLES);
  localparam int unsigned CNT_W        = $clog2(BURST_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BURST_CYCLES);

  // Queue entry sized to this instance's TID width.
  typedef struct packed {
    logic [TID_SIZE-1:0] tid;
    logic                raw;
  } entry_t;

  // ------------------------------------------------------------------
  // Outstanding-read queue
  // ------------------------------------------------------------------
  entry_t push_entry;
  entry_t head;
  logic   q_full;
  logic   q_empty;
  logic   q_pop;

  assign push_entry = '{tid: cmd_tid, raw: cmd_raw};
  assign cmd_ready  = !q_full;

  rd_tid_fifo #(
    .DEPTH   (QDEPTH),
    .entry_t (entry_t)
  ) u_tid_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (cmd_valid),
    .push_data_i (push_entry),
    .pop_i       (q_pop),
    .head_o      (head),
    .full_o      (q_full),
    .empty_o     (q_empty)
  );

  // ------------------------------------------------------------------
  // Sequencer state
  // ------------------------------------------------------------------
  rd_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic               err_unexp_d;
  logic               tmo_fire;

  logic               mux_sel_q;
  logic               fwd_req_q;
  logic               raw_strobe_q;
  logic [IDX_W-1:0]   fwd_idx_q;
  logic               tid_strobe_q;
  logic [TID_SIZE-1:0] tid_pop_q;
  logic               err_unexp_q;

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Beats are only accepted while the head is a DRAM read that has been
  // picked up; everywhere else dram_valid is dropped.
  assign strobe = dram_valid &&
                  ((state_q == DRAM_WAIT) || (state_q == DRAM_XFER));

  // The queue retires its head in TID_POP, or silently on a watchdog expiry.
  assign q_pop = (state_q == TID_POP) || tmo_fire;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_unexp_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!q_empty) begin
          state_d = head.raw ? RAW_XFER : DRAM_WAIT;
        end else if (dram_valid) begin
          err_unexp_d = 1'b1;
        end
      end
      RAW_XFER: begin
        // DRAM has nothing outstanding for a forwarded read.
        err_unexp_d = dram_valid;
        if (cnt_q == CNT_LAST) begin
          state_d = TID_POP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DRAM_WAIT: begin
        if (dram_valid) begin
          cnt_d   = CNT_W'(1);
          state_d = (BURST_CYCLES == 1) ? TID_POP : DRAM_XFER;
        end else if (tmo_fire) begin
          state_d = IDLE;
        end
      end
      DRAM_XFER: begin
        if (dram_valid) begin
          if (cnt_inc == CNT_FULL) begin
            state_d = TID_POP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          // Beats of a burst must be back to back; a hole is flagged and
          // the burst keeps waiting for its remaining beats.
          err_unexp_d = 1'b1;
        end
      end
      TID_POP: begin
        err_unexp_d = dram_valid;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State plus registered outputs decoded from the next state, so every
  // output below is a flop with no path from the inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mux_sel_q    <= 1'b0;
      fwd_req_q    <= 1'b0;
      raw_strobe_q <= 1'b0;
      fwd_idx_q    <= '0;
      tid_strobe_q <= 1'b0;
      tid_pop_q    <= '0;
      err_unexp_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mux_sel_q    <= (state_d == RAW_XFER);
      fwd_req_q    <= (state_d == RAW_XFER);
      raw_strobe_q <= (state_d == RAW_XFER);
      fwd_idx_q    <= (state_d == RAW_XFER) ? cnt_d[IDX_W-1:0] : '0;
      tid_strobe_q <= (state_d == TID_POP);
      // The head cannot change before TID_POP, so sampling it one cycle
      // early gives the TID being retired.
      tid_pop_q    <= (state_d == TID_POP) ? head.tid : '0;
      err_unexp_q  <= err_unexp_d;
    end
  end

  assign mux_sel    = mux_sel_q;
  assign fwd_req    = fwd_req_q;
  assign raw_strobe = raw_strobe_q;
  assign fwd_idx    = fwd_idx_q;
  assign tid_strobe = tid_strobe_q;
  assign tid_pop    = tid_pop_q;
  assign err_unexp  = err_unexp_q;
  assign busy       = (state_q != IDLE) || !q_empty;

  // ------------------------------------------------------------------
  // DRAM_WAIT watchdog
  // ------------------------------------------------------------------
`ifdef RD_RETURN_TIMEOUT_EN
  localparam int unsigned        TMO_W    = idx_width(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_timeout_q;

  // Counts idle DRAM_WAIT cycles; anything else (a beat, or another state)
  // restarts it from zero.
  always_comb begin
    tmo_fire = (state_q == DRAM_WAIT) && !dram_valid && (tmo_q == TMO_LAST);
    tmo_d    = '0;
    if ((state_q == DRAM_WAIT) && !dram_valid && !tmo_fire) begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q         <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      tmo_q         <= tmo_d;
      err_timeout_q <= tmo_fire;
    end
  end

  assign err_timeout = err_timeout_q;
`else
  logic unused_timeout_cfg;

  // Watchdog not built: the limit has no effect.
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign tmo_fire           = 1'b0;
  assign err_timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_rd_return_sched.sv
// ---------------------------------------------------------------------------
// tb_rd_return_sched
//   Self-checking bench for rd_return_sched. A transaction-level reference
//   model (queue of outstanding reads plus progress of the head transfer)
//   predicts every output each cycle. Directed sequences cover the main
//   scenarios, followed by randomized traffic with occasional resets.
// ---------------------------------------------------------------------------
module tb_rd_return_sched;

  localparam int TID_SIZE       = 2;
  localparam int QDEPTH         = 4;
  localparam int BURST_BEATS    = 4;
  localparam int TIMEOUT_CYCLES = 64;
  localparam int BC             = BURST_BEATS / 2;
  localparam int IDX_W          = (BC > 1) ? $clog2(BC) : 1;

  logic                clk = 1'b0;
  logic                rst;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [TID_SIZE-1:0] cmd_tid;
  logic                cmd_raw;
  logic                dram_valid;
  logic                fwd_req;
  logic [IDX_W-1:0]    fwd_idx;
  logic                mux_sel;
  logic                strobe;
  logic                raw_strobe;
  logic                tid_strobe;
  logic [TID_SIZE-1:0] tid_pop;
  logic                busy;
  logic                err_unexp;
  logic                err_timeout;

  always #5 clk = ~clk;

  rd_return_sched #(
    .TID_SIZE       (TID_SIZE),
    .QDEPTH         (QDEPTH),
    .BURST_BEATS    (BURST_BEATS),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_tid     (cmd_tid),
    .cmd_raw     (cmd_raw),
    .dram_valid  (dram_valid),
    .fwd_req     (fwd_req),
    .fwd_idx     (fwd_idx),
    .mux_sel     (mux_sel),
    .strobe      (strobe),
    .raw_strobe  (raw_strobe),
    .tid_strobe  (tid_strobe),
    .tid_pop     (tid_pop),
    .busy        (busy),
    .err_unexp   (err_unexp),
    .err_timeout (err_timeout)
  );

  // ------------------------------------------------------------------
  // Reference model
  // ------------------------------------------------------------------
  typedef struct {
    logic [TID_SIZE-1:0] tid;
    bit                  raw;
  } ent_t;

  ent_t mq[$];        // outstanding reads, oldest first
  bit   m_active;     // head transfer has been picked up
  bit   m_popping;    // head transfer complete, TID being retired this cycle
  int   m_done;       // beat pairs moved for the head
  int   m_wait;       // cycles the head DRAM read has waited with no beat
  bit   m_err;        // unexpected-beat error to report this cycle
  bit   m_tmo;        // watchdog error to report this cycle

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_active  = 0;
    m_popping = 0;
    m_done    = 0;
    m_wait    = 0;
    m_err     = 0;
    m_tmo     = 0;
  endtask

  task automatic check_outputs(input bit dv);
    bit head_raw;
    bit raw_ph;
    bit dram_ph;
    head_raw = (mq.size() > 0) ? mq[0].raw : 1'b0;
    raw_ph   = m_active && !m_popping && head_raw;
    dram_ph  = m_active && !m_popping && !head_raw;
    check("cmd_ready",   32'(cmd_ready),   32'(mq.size() < QDEPTH));
    check("mux_sel",     32'(mux_sel),     32'(raw_ph));
    check("fwd_req",     32'(fwd_req),     32'(raw_ph));
    check("raw_strobe",  32'(raw_strobe),  32'(raw_ph));
    check("fwd_idx",     32'(fwd_idx),     raw_ph ? 32'(m_done) : 32'd0);
    check("strobe",      32'(strobe),      32'(dram_ph && dv));
    check("tid_strobe",  32'(tid_strobe),  32'(m_popping));
    check("tid_pop",     32'(tid_pop),     m_popping ? 32'(mq[0].tid) : 32'd0);
    check("busy",        32'(busy),        32'(m_active || (mq.size() > 0)));
    check("err_unexp",   32'(err_unexp),   32'(m_err));
    check("err_timeout", 32'(err_timeout), 32'(m_tmo));
  endtask

  // Advance the model across one rising edge with the inputs of that cycle.
  task automatic model_step(input bit cv, input logic [TID_SIZE-1:0] tid,
                            input bit raw, input bit dv);
    bit   accept;
    bit   err;
    bit   tmo;
    ent_t e;
    accept = cv && (mq.size() < QDEPTH);
    err    = 0;
    tmo    = 0;
    if (m_popping) begin
      mq.delete(0);
      m_active  = 0;
      m_popping = 0;
      err       = dv;
    end else if (m_active) begin
      if (mq[0].raw) begin
        err = dv;
        m_done++;
        if (m_done == BC) m_popping = 1;
      end else if (dv) begin
        m_done++;
        m_wait = 0;
        if (m_done == BC) m_popping = 1;
      end else if (m_done > 0) begin
        err = 1;
      end else begin
`ifdef RD_RETURN_TIMEOUT_EN
        m_wait++;
        if (m_wait == TIMEOUT_CYCLES) begin
          mq.delete(0);
          m_active = 0;
          m_wait   = 0;
          tmo      = 1;
        end
`endif
      end
    end else if (mq.size() > 0) begin
      m_active = 1;
      m_done   = 0;
      m_wait   = 0;
    end else begin
      err = dv;
    end
    if (accept) begin
      e.tid = tid;
      e.raw = raw;
      mq.push_back(e);
    end
    m_err = err;
    m_tmo = tmo;
  endtask

  // One clock cycle: drive inputs at the falling edge, check just after,
  // then let the model follow the rising edge.
  task automatic run_cycle(input bit cv, input logic [TID_SIZE-1:0] tid,
                           input bit raw, input bit dv);
    @(negedge clk);
    cmd_valid  = cv;
    cmd_tid    = tid;
    cmd_raw    = raw;
    dram_valid = dv;
    #1;
    check_outputs(dv);
    if (m_popping) $display("pop tid=%0d @%0t", mq[0].tid, $time);
    @(posedge clk);
    model_step(cv, tid, raw, dv);
  endtask

  // Asynchronous reset asserted wherever the caller happens to be in the
  // cycle; outputs are checked before any clock edge arrives.
  task automatic apply_reset();
    cmd_valid  = 0;
    cmd_tid    = '0;
    cmd_raw    = 0;
    dram_valid = 0;
    rst        = 1;
    model_clear();
    #1;
    check_outputs(1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    model_step(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    int pushed;
    bit cv;

    apply_reset();

    // DRAM read, tid 1: two contiguous beat pairs.
    run_cycle(1, 2'd1, 0, 0);
    run_cycle(0, 2'd0, 0, 0);
    run_cycle(0, 2'd0, 0, 1);
    run_cycle(0, 2'd0, 0, 1);
    repeat (3) run_cycle(0, 2'd0, 0, 0);

    // Forwarded read, tid 2, with a stray DRAM beat during the burst.
    run_cycle(1, 2'd2, 1, 0);
    run_cycle(0, 2'd0, 0, 0);
    run_cycle(0, 2'd0, 0, 1);
    run_cycle(0, 2'd0, 0, 0);
    repeat (3) run_cycle(0, 2'd0, 0, 0);

    // Fill the queue with tids 0..3, hold a 5th request until space frees.
    pushed = 0;
    for (int i = 0; i < 40; i++) begin
      cv = (pushed < 5);
      if (cv && (mq.size() < QDEPTH)) begin
        run_cycle(1, 2'(pushed), pushed[0], 1);
        pushed++;
      end else begin
        run_cycle(cv, 2'(pushed), pushed[0], 1);
      end
    end
    repeat (4) run_cycle(0, 2'd0, 0, 0);

    // DRAM burst with a one-cycle hole between its beat pairs.
    run_cycle(1, 2'd1, 0, 0);
    run_cycle(0, 2'd0, 0, 0);
    run_cycle(0, 2'd0, 0, 1);
    run_cycle(0, 2'd0, 0, 0);
    run_cycle(0, 2'd0, 0, 1);
    repeat (3) run_cycle(0, 2'd0, 0, 0);

    // Reset in the middle of a forwarded burst: nothing retires afterwards.
    run_cycle(1, 2'd2, 1, 0);
    run_cycle(1, 2'd3, 0, 0);
    run_cycle(0, 2'd0, 0, 0);
    #2;
    apply_reset();
    repeat (4) run_cycle(0, 2'd0, 0, 0);

`ifdef RD_RETURN_TIMEOUT_EN
    // DRAM read that never gets data: the watchdog drops it.
    run_cycle(1, 2'd3, 0, 0);
    repeat (TIMEOUT_CYCLES + 6) run_cycle(0, 2'd0, 0, 0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        #2;
        apply_reset();
      end else begin
        run_cycle($urandom_range(0, 99) < 40,
                  TID_SIZE'($urandom),
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 99) < 45);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rd_return_sched.md
Name: rd_return_sched

Overview:
- Sequences the read-return data buffer in the DDR controller.
- Holds an in-order queue of outstanding read transactions, each a TID plus a read-after-write (RAW) flag.
- Per head entry, either gates DRAM beats into the buffer (strobe) or drives write-buffer forwarded beats (raw_strobe), then pops the TID (tid_strobe/tid_pop).
- Owns the mux select between the DRAM and forward data paths; sits between the command scheduler and data_buffer.

Parameters:
- TID_SIZE, 2, width of transaction ID.
- QDEPTH, 4, outstanding-read queue entries (power of 2).
- BURST_BEATS, 4, 64-bit beats per burst (even); localparam BURST_CYCLES = BURST_BEATS/2, since DDR gives 2 beats per clk.
- TIMEOUT_CYCLES, 64, DRAM_WAIT watchdog limit (only used with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  read issued to DRAM or RAW hit.
- cmd_ready  out  1  queue not full.
- cmd_tid  in  TID_SIZE  TID of read.
- cmd_raw  in  1  1 = data comes from write-buffer forward path.
- dram_valid  in  1  DRAM beat pair present this cycle.
- fwd_req  out  1  request forwarded beat pair from write buffer.
- fwd_idx  out  $clog2(BURST_CYCLES) (min 1)  beat-pair index requested.
- mux_sel  out  1  0 = DRAM data, 1 = forward data onto mux_data.
- strobe  out  1  to data_buffer strobe.
- raw_strobe  out  1  to data_buffer raw_strobe.
- tid_strobe  out  1  to data_buffer tid_strobe.
- tid_pop  out  TID_SIZE  to data_buffer tid_pop.
- busy  out  1  state != IDLE or queue non-empty.
- err_unexp  out  1  one-cycle pulse: dram_valid with no DRAM read pending.
- err_timeout  out  1  one-cycle pulse: watchdog expiry (0 without the optional feature).

Behaviour:
- Reset (async, rst=1): queue emptied, state IDLE, counters 0. Outputs: cmd_ready=1, every other output 0.
- Queue: enqueue on cmd_valid&cmd_ready. Pop happens in the TID_POP cycle.
  - Enqueue and pop in the same cycle are both honoured, count unchanged.
  - cmd_ready = !full (combinational), so a full queue accepts its next entry the cycle after a pop.
- IDLE:
  - Queue non-empty → RAW_XFER if head.raw, else DRAM_WAIT.
  - An entry enqueued into an empty queue is seen in IDLE the next cycle.
- RAW_XFER:
  - mux_sel=1, fwd_req=1, raw_strobe=1 for exactly BURST_CYCLES consecutive cycles.
  - fwd_idx counts 0..BURST_CYCLES-1, then → TID_POP.
- DRAM_WAIT:
  - mux_sel=0; strobe = dram_valid (combinational).
  - dram_valid → beat counter = 1; → DRAM_XFER, or TID_POP if BURST_CYCLES==1.
- DRAM_XFER:
  - strobe = dram_valid. Beats must be contiguous.
  - Gap (dram_valid=0): err_unexp pulses; counter holds; wait continues.
  - Counter reaches BURST_CYCLES → TID_POP.
- TID_POP:
  - One cycle: tid_strobe=1, tid_pop=head.tid, queue pops → IDLE.
  - Back-to-back bursts therefore have ≥2 idle cycles (TID_POP, IDLE).
- dram_valid in IDLE with empty queue, in RAW_XFER, or in TID_POP → err_unexp pulse; strobe stays 0 and the beat is dropped.
- Outputs other than strobe and cmd_ready are registered-state decodes with no input-to-output combinational path.
- Reset mid-burst aborts the burst immediately. No tid_strobe is issued and all queue entries are lost.

Optional Feature:
- Macro RD_RETURN_TIMEOUT_EN.
- Defined:
  - A counter runs in DRAM_WAIT.
  - After TIMEOUT_CYCLES cycles with no dram_valid: err_timeout pulses one cycle, the head is dropped (no tid_strobe), → IDLE.
  - The counter clears on leaving DRAM_WAIT.
- Undefined: DRAM_WAIT waits indefinitely; err_timeout tied 0; no counter logic.

Decomposition:
- rd_return_pkg holds:
  - state enum {IDLE, RAW_XFER, DRAM_WAIT, DRAM_XFER, TID_POP};
  - rd_entry_t struct {tid, raw};
  - default parameter constants.
- One sub-module: rd_tid_fifo, a parameterised sync FIFO of rd_entry_t with full/empty and simultaneous push/pop.

Test Plan:
- Reset: rst pulsed mid-RAW_XFER → all outputs 0, cmd_ready=1 asynchronously; no tid_strobe afterwards.
- DRAM read: enqueue tid=1 raw=0; dram_valid 2 cycles → strobe 2 cycles, mux_sel=0; then tid_strobe 1 cycle with tid_pop=1; busy drops after.
- RAW read: enqueue tid=2 raw=1 → raw_strobe/fwd_req 2 cycles with fwd_idx 0,1 and mux_sel=1; then tid_strobe with tid_pop=2; dram_valid asserted during the burst → err_unexp.
- Ordering/full: enqueue tids 0,1,2,3 (raw=0,1,0,1) → cmd_ready=0 after 4th; a 5th cmd_valid is held until the first TID_POP; pops occur in order 0,1,2,3.
- DRAM gap: dram_valid 1,0,1 → strobe 1,0,1; err_unexp pulse on the gap cycle; tid_strobe after the 2nd valid.
- RD_RETURN_TIMEOUT_EN: enqueue tid=3 raw=0 with no dram_valid → err_timeout after 64 cycles, no tid_strobe, queue empty.
